alu_issuer: RTL and testbench
=============================

Name: alu_issuer

Overview:
- Sequential front end for the 32-bit structural alu.
- Accepts operation requests (opcode, operands, tag) over a valid/ready handshake and registers the operands into an issue stage that drives the ALU ports.
- Captures result and flags into a response FIFO, returned over a second valid/ready handshake.
- Sits between the instruction/control logic and the combinational alu; keeps sustained 1 op/cycle throughput when the consumer is ready.

Parameters:
- N, 32, operand/result width (only 32 supported).
- DEPTH, 4, response FIFO entries (power of two, ≥2).
- TAG_W, 4, width of the request tag carried through to the response.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid & req_ready at the edge.
- req_op  input  4  alu_control_t opcode.
- req_a  input  N  operand a.
- req_b  input  N  operand b.
- req_tag  input  TAG_W  opaque tag.
- alu_a  output  N  to alu a.
- alu_b  output  N  to alu b.
- alu_control  output  4  to alu control.
- alu_result  input  N  from alu.
- alu_overflow  input  1  from alu.
- alu_zero  input  1  from alu.
- alu_equal  input  1  from alu.
- rsp_valid  output  1  FIFO non-empty.
- rsp_ready  input  1  consumer pop.
- rsp_result  output  N  head result.
- rsp_overflow  output  1  head overflow.
- rsp_zero  output  1  head zero.
- rsp_equal  output  1  head equal.
- rsp_err  output  1  head was an illegal opcode.
- rsp_tag  output  TAG_W  head tag.
- ovf_count  output  16  saturating count of overflowed ADD/SUB responses written.
- idle  output  1  issue stage empty and FIFO empty.

Behaviour:
- Reset (async, rst_n=0): issue_valid=0, FIFO count/pointers=0, ovf_count=0; alu_a=alu_b=0, alu_control=0; rsp_valid=0, req_ready=1, idle=1. Reset mid-operation discards all in-flight requests and responses.
- Issue stage:
  - On accept, latch req_op/req_a/req_b/req_tag and set issue_valid.
  - alu_a, alu_b and alu_control come directly from these registers; they hold their last value when issue_valid=0.
  - issue_valid clears on the next edge unless a new accept occurs in the same cycle.
- Writeback: when issue_valid=1, the edge writes the ALU outputs into the FIFO tail.
- Latency: accept at edge k → rsp_valid visible after edge k+1 (FIFO empty case).
- Flow control:
  - req_ready = (count + issue_valid) < DEPTH, using registered count.
  - A same-cycle pop is not credited (conservative).
  - An issued op is therefore never blocked; no back-pressure into the issue stage.
- FIFO:
  - Push and pop in the same cycle keep count unchanged.
  - Pop when empty is ignored.
  - Head outputs are stable while rsp_valid=1 and rsp_ready=0.
  - Pointers wrap modulo DEPTH.
- Opcode legality:
  - Legal opcodes: AND=1, OR=2, XOR=3, SLL=5, SRL=6, SRA=7, ADD=8, SUB=12, SLT=13, SLTU=15.
  - Any other opcode: response stored with rsp_err=1 and result/overflow/zero/equal = 0. It still consumes a slot and preserves order.
- Flag masking:
  - Stored overflow = alu_overflow only for ADD/SUB, else 0.
  - zero and equal are stored as the ALU reports them.
- ovf_count: increments on each FIFO write whose stored overflow=1; saturates at 16'hFFFF.
- Ordering: responses leave in request order; the tag is carried unchanged.

Decomposition:
- alu_types package (existing) owns alu_control_t and the opcode constants.
- Add to it: an is_legal_op function and a response struct typedef (result, overflow, zero, equal, err, tag).
- One sub-module: resp_fifo (parameterised DEPTH/width, synchronous, async active-low reset, count output).

Test Plan:
- Reset then single ADD a=5, b=7, tag=3 → rsp_valid two edges after accept; result=12, zero=0, overflow=0, tag=3; idle returns to 1 after pop.
- SUB a=32'h8000_0000, b=1 → result=32'h7FFF_FFFF, overflow=1, ovf_count=1. XOR a=b=32'hA5A5_A5A5 → result=0, zero=1, equal=1, overflow=0.
- rsp_ready=0, issue 6 back-to-back requests → exactly 4 accepted (req_ready drops once count+issue_valid=4). Release rsp_ready → responses drain in order and the remaining 2 are accepted.
- rsp_ready held 1, 100 consecutive random legal ops → one accept per cycle; every response matches the golden ALU model and tags are in order.
- Illegal opcode 4 between two ANDs → middle response has err=1, result=0; neighbours correct; order preserved.
- Assert rst_n low with 3 responses queued and one op in issue → rsp_valid=0, ovf_count=0 immediately (asynchronous); no stale response after rst_n releases.

Source files
------------

// File: rtl/alu_types_pkg.sv
// Shared ALU opcode encoding, response payload and opcode helpers
// for the alu_issuer front end.
package alu_types_pkg;

  localparam int unsigned ALU_N     = 32;
  localparam int unsigned ALU_TAG_W = 4;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_ADD  = 4'd8,
    ALU_SUB  = 4'd12,
    ALU_SLT  = 4'd13,
    ALU_SLTU = 4'd15
  } alu_control_t;

  typedef struct packed {
    logic [ALU_N-1:0]     result;
    logic                 overflow;
    logic                 zero;
    logic                 equal;
    logic                 err;
    logic [ALU_TAG_W-1:0] tag;
  } alu_rsp_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU: is_legal_op = 1'b1;
      default:                             is_legal_op = 1'b0;
    endcase
  endfunction

  // Only arithmetic ops can meaningfully report signed overflow.
  function automatic logic has_overflow(input logic [3:0] op);
    has_overflow = (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO with occupancy count; pointers wrap modulo DEPTH.
module resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && (count != CW'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issuer.sv
// Registered issue stage in front of the combinational ALU, with an
// in-order response FIFO and a saturating overflow counter.
module alu_issuer
  import alu_types_pkg::*;
#(
  parameter int unsigned N     = ALU_N,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = ALU_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [N-1:0]     req_a,
  input  logic [N-1:0]     req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_control,
  input  logic [N-1:0]     alu_result,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  input  logic             alu_equal,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic             rsp_equal,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      ovf_count,
  output logic             idle
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             issue_valid;
  logic [TAG_W-1:0] issue_tag;
  logic [CW-1:0]    count;
  logic             accept;
  logic             legal;
  alu_rsp_t         wdata;
  alu_rsp_t         head;

  // Credit check uses registered state only; a same-cycle pop is not counted.
  assign req_ready = (count + CW'(issue_valid)) < CW'(DEPTH);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      issue_tag   <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
    end else begin
      issue_valid <= accept;
      if (accept) begin
        issue_tag   <= req_tag;
        alu_a       <= req_a;
        alu_b       <= req_b;
        alu_control <= req_op;
      end
    end
  end

  // Illegal opcodes still occupy a slot so order is preserved, but carry no data.
  always_comb begin
    legal          = is_legal_op(alu_control);
    wdata          = '0;
    wdata.tag      = issue_tag;
    wdata.err      = !legal;
    if (legal) begin
      wdata.result   = alu_result;
      wdata.overflow = alu_overflow && has_overflow(alu_control);
      wdata.zero     = alu_zero;
      wdata.equal    = alu_equal;
    end
  end

  resp_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(alu_rsp_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (issue_valid),
    .wdata (wdata),
    .pop   (rsp_ready),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (issue_valid && wdata.overflow && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end

  assign rsp_valid    = (count != '0);
  assign rsp_result   = head.result;
  assign rsp_overflow = head.overflow;
  assign rsp_zero     = head.zero;
  assign rsp_equal    = head.equal;
  assign rsp_err      = head.err;
  assign rsp_tag      = head.tag;
  assign idle         = !issue_valid && (count == '0);

endmodule

// File: tb/tb_alu_issuer.sv
// Directed and scoreboarded checks of alu_issuer against a behavioural ALU.
module tb_alu_issuer;
  import alu_types_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_tag;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        alu_zero;
  logic        alu_equal;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_overflow;
  logic        rsp_zero;
  logic        rsp_equal;
  logic        rsp_err;
  logic [3:0]  rsp_tag;
  logic [15:0] ovf_count;
  logic        idle;

  int n_vec;
  int n_err;

  alu_issuer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_tag      (req_tag),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .alu_equal    (alu_equal),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .rsp_equal    (rsp_equal),
    .rsp_err      (rsp_err),
    .rsp_tag      (rsp_tag),
    .ovf_count    (ovf_count),
    .idle         (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: {result, overflow, zero, equal}; garbage on undefined opcodes.
  function automatic logic [34:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      4'd1:  r = a & b;
      4'd2:  r = a | b;
      4'd3:  r = a ^ b;
      4'd5:  r = a << b[4:0];
      4'd6:  r = a >> b[4:0];
      4'd7:  r = $signed(a) >>> b[4:0];
      4'd8:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd12: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd13: r = {31'd0, $signed(a) < $signed(b)};
      4'd15: r = {31'd0, a < b};
      default: return {32'hDEAD_BEEF, 3'b111};
    endcase
    return {r, v, r == 32'd0, a == b};
  endfunction

  always_comb {alu_result, alu_overflow, alu_zero, alu_equal} = alu_ref(alu_control, alu_a, alu_b);

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    int t;
    t = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    while (!req_ready && t < 20) begin tick(); t++; end
    check("send_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input logic [31:0] res, input logic ovf,
                            input logic zero, input logic eq, input logic err,
                            input logic [3:0] tag);
    int t;
    t = 0;
    while (!rsp_valid && t < 20) begin tick(); t++; end
    check({name, "_valid"}, rsp_valid, 1);
    check({name, "_result"}, rsp_result, res);
    check({name, "_flags"}, {rsp_overflow, rsp_zero, rsp_equal, rsp_err}, {ovf, zero, eq, err});
    check({name, "_tag"}, rsp_tag, tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [3:0]  legal [10];
    alu_rsp_t    exp_q[$];
    alu_rsp_t    e;
    logic [34:0] m;
    int          idx;
    int          j;
    int          sent;
    int          rcvd;

    legal = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12, 4'd13, 4'd15};
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    rsp_ready = 1'b0;
    repeat (2) tick();

    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_idle", idle, 1);
    check("rst_ovf_count", ovf_count, 0);
    check("rst_alu_ports", {alu_a, alu_b, alu_control}, 0);
    rst_n = 1'b1;
    tick();

    // Single ADD: latency and idle return
    req_valid = 1'b1; req_op = 4'd8; req_a = 32'd5; req_b = 32'd7; req_tag = 4'd3;
    check("add_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("add_edge1_rsp_valid", rsp_valid, 0);
    check("add_issue_ports", {alu_a, alu_b, alu_control}, {32'd5, 32'd7, 4'd8});
    check("add_edge1_idle", idle, 0);
    tick();
    check("add_edge2_rsp_valid", rsp_valid, 1);
    check("add_result", rsp_result, 32'd12);
    check("add_flags", {rsp_overflow, rsp_zero, rsp_equal, rsp_err}, 4'b0000);
    check("add_tag", rsp_tag, 4'd3);
    check("add_hold_ports", {alu_a, alu_control}, {32'd5, 4'd8});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("add_idle_after_pop", idle, 1);
    check("add_empty_after_pop", rsp_valid, 0);

    // SUB overflow and XOR zero/equal
    send(4'd12, 32'h8000_0000, 32'd1, 4'd4);
    expect_rsp("sub", 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    check("sub_ovf_count", ovf_count, 16'd1);
    send(4'd3, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'd5);
    expect_rsp("xor", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5);
    check("xor_ovf_count", ovf_count, 16'd1);

    // Back-pressure: six requests against a stalled consumer
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_op = 4'd8; req_a = 32'(idx); req_b = 32'd1; req_tag = 4'(idx);
      if (req_ready) idx++;
      tick();
    end
    check("bp_accepted", 32'(idx), 32'd4);
    check("bp_ready_low", req_ready, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_head_tag", rsp_tag, 4'd0);
    rsp_ready = 1'b1;
    j = 0;
    for (int c = 0; c < 40 && j < 6; c++) begin
      if (idx < 6) begin
        req_valid = 1'b1; req_a = 32'(idx); req_tag = 4'(idx);
      end else begin
        req_valid = 1'b0;
      end
      if (rsp_valid) begin
        check("bp_drain_result", rsp_result, 32'(j + 1));
        check("bp_drain_tag", rsp_tag, 4'(j));
        j++;
      end
      if (req_valid && req_ready) idx++;
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("bp_drained", 32'(j), 32'd6);
    check("bp_ovf_count", ovf_count, 16'd1);

    // Illegal opcode sandwiched between ANDs
    send(4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd7);
    send(4'd4, 32'd1, 32'd1, 4'd8);
    send(4'd1, 32'd3, 32'd5, 4'd9);
    expect_rsp("and0", 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7);
    expect_rsp("illegal", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
    expect_rsp("and1", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9);
    check("illegal_ovf_count", ovf_count, 16'd1);

    // Asynchronous reset with three queued responses and one op in issue
    send(4'd8, 32'h7FFF_FFFF, 32'd1, 4'd1);
    send(4'd8, 32'd1, 32'd1, 4'd2);
    send(4'd12, 32'd0, 32'd0, 4'd3);
    send(4'd8, 32'd2, 32'd2, 4'd4);
    check("prerst_rsp_valid", rsp_valid, 1);
    check("prerst_ovf_count", ovf_count, 16'd2);
    check("prerst_busy", idle, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", rsp_valid, 0);
    check("async_rst_ovf_count", ovf_count, 16'd0);
    check("async_rst_idle", idle, 1);
    check("async_rst_ready", req_ready, 1);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("postrst_no_stale", rsp_valid, 0);
    check("postrst_idle", idle, 1);
    send(4'd8, 32'd9, 32'd1, 4'd5);
    expect_rsp("postrst_add", 32'd10, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);

    // Sustained random legal traffic with a ready consumer
    rsp_ready = 1'b1;
    sent = 0; rcvd = 0;
    for (int c = 0; c < 400 && rcvd < 100; c++) begin
      if (sent < 100) begin
        req_valid = 1'b1;
        req_op    = legal[$urandom_range(9, 0)];
        req_a     = $urandom;
        req_b     = $urandom;
        req_tag   = 4'(sent);
      end else begin
        req_valid = 1'b0;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_rsp", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("rand_result", rsp_result, e.result);
          check("rand_flags", {rsp_overflow, rsp_zero, rsp_equal, rsp_err},
                {e.overflow, e.zero, e.equal, e.err});
          check("rand_tag", rsp_tag, e.tag);
        end
        rcvd++;
      end
      if (req_valid) begin
        check("rand_ready", req_ready, 1);
        if (req_ready) begin
          m = alu_ref(req_op, req_a, req_b);
          e.result   = m[34:3];
          e.overflow = m[2];
          e.zero     = m[1];
          e.equal    = m[0];
          e.err      = 1'b0;
          e.tag      = req_tag;
          exp_q.push_back(e);
          sent++;
        end
      end
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("rand_received", 32'(rcvd), 32'd100);
    check("rand_idle", idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
